// File: rtl/pipe_stage_reg.sv
// Y86-64 pipeline stage register: stat/icode/ifun header plus opaque payload,
// stall/bubble control, sticky conflict flag, optional counters (PIPE_STAGE_REG_PERF_EN).
module pipe_stage_reg #(
  parameter int                PAYLOAD_W   = 136,
  parameter int                STAT_W      = 3,
  parameter logic [3:0]        NOP_ICODE   = 4'h1,
  parameter logic [STAT_W-1:0] STAT_BUBBLE = 3'b001,
  parameter int                CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic                 in_valid,
  input  logic [STAT_W-1:0]    in_stat,
  input  logic [3:0]           in_icode,
  input  logic [3:0]           in_ifun,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic                 out_is_bubble,
  output logic [STAT_W-1:0]    out_stat,
  output logic [3:0]           out_icode,
  output logic [3:0]           out_ifun,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 ctl_err,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     instr_cnt
);

  logic                 r_valid;
  logic                 r_is_bubble;
  logic [STAT_W-1:0]    r_stat;
  logic [3:0]           r_icode;
  logic [3:0]           r_ifun;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_ctl_err;

  logic w_load;
  logic w_hold;
  logic w_conflict;

  // Bubble dominates stall; a load happens only when neither is asserted.
  assign w_hold     = stall & ~bubble;
  assign w_load     = ~stall & ~bubble;
  assign w_conflict = stall & bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_is_bubble <= 1'b1;
      r_stat      <= STAT_BUBBLE;
      r_icode     <= NOP_ICODE;
      r_ifun      <= 4'h0;
      r_payload   <= '0;
    end else if (bubble) begin
      r_valid     <= 1'b0;
      r_is_bubble <= 1'b1;
      r_stat      <= STAT_BUBBLE;
      r_icode     <= NOP_ICODE;
      r_ifun      <= 4'h0;
      r_payload   <= '0;
    end else if (w_load) begin
      r_valid     <= in_valid;
      r_is_bubble <= 1'b0;
      r_stat      <= in_stat;
      r_icode     <= in_icode;
      r_ifun      <= in_ifun;
      r_payload   <= in_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl_err <= 1'b0;
    end else if (cnt_clr) begin
      r_ctl_err <= 1'b0;
    end else if (w_conflict) begin
      r_ctl_err <= 1'b1;
    end
  end

  assign out_valid     = r_valid;
  assign out_is_bubble = r_is_bubble;
  assign out_stat      = r_stat;
  assign out_icode     = r_icode;
  assign out_ifun      = r_ifun;
  assign out_payload   = r_payload;
  assign ctl_err       = r_ctl_err;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_instr_inc;

  assign w_instr_inc = w_load & in_valid;

  // Saturating counters; clear takes priority over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_instr_cnt  <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_instr_cnt  <= '0;
    end else begin
      if (w_hold && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bubble && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (w_instr_inc && (r_instr_cnt != '1))
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign instr_cnt  = r_instr_cnt;
`else
  logic w_unused_hold;
  assign w_unused_hold = w_hold;
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign instr_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a slot-level model.
// Counter expectations follow PIPE_STAGE_REG_PERF_EN (zero when undefined).
module tb_pipe_stage_reg;
  localparam int PW = 136;
  localparam int SW = 3;
  localparam int CW = 4;
`ifdef PIPE_STAGE_REG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, bubble, in_valid, cnt_clr;
  logic [SW-1:0] in_stat;
  logic [3:0]    in_icode, in_ifun;
  logic [PW-1:0] in_payload;
  logic          out_valid, out_is_bubble, ctl_err;
  logic [SW-1:0] out_stat;
  logic [3:0]    out_icode, out_ifun;
  logic [PW-1:0] out_payload;
  logic [CW-1:0] stall_cnt, bubble_cnt, instr_cnt;

  int n_total = 0;
  int n_pass  = 0;

  pipe_stage_reg #(.PAYLOAD_W(PW), .STAT_W(SW), .NOP_ICODE(4'h1),
                   .STAT_BUBBLE(3'b001), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .in_valid(in_valid), .in_stat(in_stat), .in_icode(in_icode),
    .in_ifun(in_ifun), .in_payload(in_payload),
    .out_valid(out_valid), .out_is_bubble(out_is_bubble), .out_stat(out_stat),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_payload(out_payload),
    .ctl_err(ctl_err), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .instr_cnt(instr_cnt));

  always #5 clk = ~clk;

  // Model: the slot contents as a record plus plain event tallies.
  typedef struct {
    logic          valid;
    logic          is_bub;
    logic [SW-1:0] stat;
    logic [3:0]    icode;
    logic [3:0]    ifun;
    logic [PW-1:0] payload;
  } slot_t;

  slot_t m_slot;
  logic  m_err;
  int    m_nstall, m_nbub, m_ninstr;

  function automatic slot_t nop_slot();
    slot_t s;
    s.valid = 1'b0; s.is_bub = 1'b1; s.stat = 3'b001;
    s.icode = 4'h1; s.ifun = 4'h0; s.payload = '0;
    return s;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(int n);
    if (!PERF) return '0;
    return (n >= 15) ? 4'hF : CW'(n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot = nop_slot();
      m_err = 1'b0;
      m_nstall = 0; m_nbub = 0; m_ninstr = 0;
    end else begin
      if (bubble) m_slot = nop_slot();
      else if (!stall) begin
        m_slot.valid = in_valid; m_slot.is_bub = 1'b0; m_slot.stat = in_stat;
        m_slot.icode = in_icode; m_slot.ifun = in_ifun; m_slot.payload = in_payload;
      end
      if (cnt_clr) begin
        m_err = 1'b0;
        m_nstall = 0; m_nbub = 0; m_ninstr = 0;
      end else begin
        if (stall && bubble) m_err = 1'b1;
        if (stall && !bubble) m_nstall++;
        if (bubble) m_nbub++;
        if (!stall && !bubble && in_valid) m_ninstr++;
      end
    end
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("valid",   160'(out_valid),     160'(m_slot.valid));
    chk("is_bub",  160'(out_is_bubble), 160'(m_slot.is_bub));
    chk("stat",    160'(out_stat),      160'(m_slot.stat));
    chk("icode",   160'(out_icode),     160'(m_slot.icode));
    chk("ifun",    160'(out_ifun),      160'(m_slot.ifun));
    chk("payload", 160'(out_payload),   160'(m_slot.payload));
    chk("ctl_err", 160'(ctl_err),       160'(m_err));
    chk("stall_cnt",  160'(stall_cnt),  160'(exp_cnt(m_nstall)));
    chk("bubble_cnt", 160'(bubble_cnt), 160'(exp_cnt(m_nbub)));
    chk("instr_cnt",  160'(instr_cnt),  160'(exp_cnt(m_ninstr)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; bubble = 0; cnt_clr = 0; in_valid = 0;
  endtask

  task automatic load(input logic [3:0] ic, input logic [PW-1:0] pl);
    in_valid = 1; in_stat = 3'b001; in_icode = ic; in_ifun = 4'h0; in_payload = pl;
  endtask

  logic [159:0] rnd;

  initial begin
    rst_n = 1; stall = 0; bubble = 0; cnt_clr = 0;
    in_valid = 1; in_stat = 3'b010; in_icode = 4'h7; in_ifun = 4'h2; in_payload = PW'(16'h1234);
    #1 rst_n = 0;
    repeat (3) tick();
    chk("rst_stat",   160'(out_stat), 160'(3'b001));
    chk("rst_icode",  160'(out_icode), 160'(4'h1));
    chk("rst_pay",    160'(out_payload), 160'(0));
    chk("rst_valid",  160'(out_valid), 160'(0));
    chk("rst_isbub",  160'(out_is_bubble), 160'(1));
    rst_n = 1;
    tick();
    chk("rel_icode",  160'(out_icode), 160'(4'h7));
    chk("rel_stat",   160'(out_stat), 160'(3'b010));

    // Normal load after a counter clear
    idle(); cnt_clr = 1; tick();
    idle(); load(4'h3, PW'(16'hABCD)); tick();
    chk("ld_icode", 160'(out_icode), 160'(4'h3));
    chk("ld_pay",   160'(out_payload), 160'(16'hABCD));
    chk("ld_isbub", 160'(out_is_bubble), 160'(0));
    chk("ld_instr", 160'(instr_cnt), 160'(PERF ? 1 : 0));

    // Stall for three edges while upstream changes
    load(4'h6, PW'(5)); tick();
    stall = 1; load(4'h2, PW'(9));
    repeat (3) tick();
    chk("st_icode", 160'(out_icode), 160'(4'h6));
    chk("st_cnt",   160'(stall_cnt), 160'(PERF ? 3 : 0));
    stall = 0; tick();
    chk("st_rel",   160'(out_icode), 160'(4'h2));

    // Bubble scrubs a live slot
    load(4'h5, PW'(64'hDEAD_BEEF)); tick();
    in_stat = 3'b100; bubble = 1; tick();
    bubble = 0;
    chk("bb_icode", 160'(out_icode), 160'(4'h1));
    chk("bb_pay",   160'(out_payload), 160'(0));
    chk("bb_stat",  160'(out_stat), 160'(3'b001));
    chk("bb_valid", 160'(out_valid), 160'(0));
    chk("bb_cnt",   160'(bubble_cnt), 160'(PERF ? 1 : 0));

    // Conflict: sticky until clear
    stall = 1; bubble = 1; tick();
    chk("cf_err",   160'(ctl_err), 160'(1));
    chk("cf_isbub", 160'(out_is_bubble), 160'(1));
    idle(); repeat (5) tick();
    chk("cf_hold",  160'(ctl_err), 160'(1));
    cnt_clr = 1; stall = 1; bubble = 1; tick();
    idle();
    chk("cf_clr",   160'(ctl_err), 160'(0));
    chk("cf_bcnt",  160'(bubble_cnt), 160'(0));
    chk("cf_scnt",  160'(stall_cnt), 160'(0));

    // Saturation
    stall = 1; repeat (20) tick();
    chk("sat_stall", 160'(stall_cnt), 160'(PERF ? 15 : 0));
    chk("mdl_sat",   160'(exp_cnt(m_nstall)), 160'(PERF ? 15 : 0));

    // Reset during a stall drops the held slot immediately
    load(4'h9, PW'(3)); stall = 0; tick();
    stall = 1; tick();
    rst_n = 0; #1;
    chk("rst_mid_icode", 160'(out_icode), 160'(4'h1));
    chk("rst_mid_err",   160'(ctl_err), 160'(0));
    tick(); rst_n = 1; idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_payload = rnd[PW-1:0];
      in_stat  = SW'($urandom_range(0, 7));
      in_icode = 4'($urandom_range(0, 15));
      in_ifun  = 4'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      bubble   = ($urandom_range(0, 7) == 0);
      cnt_clr  = ($urandom_range(0, 40) == 0);
      if (i % 150 == 75) begin
        rst_n = 0; tick(); rst_n = 1;
      end else tick();
    end
    idle(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the Y86-64 pipelined core, generalising the fetch-to-decode register to serve any inter-stage boundary (F/D, D/E, E/M, M/W). It captures a stat/icode/ifun header plus an opaque packed payload every clock, and supports stall (hold) and bubble (NOP injection with payload scrub). It adds a valid/bubble tag, a sticky control-conflict flag and optional saturating performance counters.

## Interface
Parameters:
- PAYLOAD_W, 136: packed payload width (rA 4 + rB 4 + valC 64 + valP 64 for F/D)
- STAT_W, 3: status field width
- NOP_ICODE, 4'h1: icode loaded on bubble
- STAT_BUBBLE, 3'b001: stat loaded on bubble and reset (AOK)
- CNT_W, 32: performance counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  stage clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current contents
- bubble  in  1  inject NOP
- in_valid  in  1  upstream slot holds a real instruction
- in_stat  in  STAT_W  upstream status
- in_icode  in  4  upstream icode
- in_ifun  in  4  upstream ifun
- in_payload  in  PAYLOAD_W  upstream packed fields
- out_valid  out  1  registered slot holds a real instruction
- out_is_bubble  out  1  registered slot was produced by bubble or reset
- out_stat  out  STAT_W  registered status
- out_icode  out  4  registered icode
- out_ifun  out  4  registered ifun
- out_payload  out  PAYLOAD_W  registered payload
- ctl_err  out  1  sticky: stall and bubble seen together
- cnt_clr  in  1  synchronous clear of counters and ctl_err
- stall_cnt, bubble_cnt, instr_cnt  out  CNT_W each  performance counters (see Configuration)

## Operation
- Reset (rst_n=0, immediate): out_stat=STAT_BUBBLE, out_icode=NOP_ICODE, out_ifun=0, out_payload=0, out_valid=0, out_is_bubble=1, ctl_err=0, all counters 0.
- Per rising edge, priority bubble > stall > load:
  - bubble=1: load stat=STAT_BUBBLE, icode=NOP_ICODE, ifun=0, payload=0, valid=0, is_bubble=1. Upstream stat is not propagated.
  - stall=1, bubble=0: all outputs hold.
  - else load: all fields from inputs; out_valid=in_valid; out_is_bubble=0.
- stall=1 and bubble=1 in the same cycle: bubble wins; ctl_err sets and stays set until cnt_clr or reset.
- cnt_clr=1: ctl_err and counters clear on that edge; clear beats a simultaneous set or increment.
- Counters (when compiled in) saturate at all-ones with no wrap:
  - stall_cnt +1 per edge with stall=1 and bubble=0.
  - bubble_cnt +1 per edge with bubble=1.
  - instr_cnt +1 per load edge with in_valid=1.

## Timing
- Latency 1 cycle input to output on a load; no combinational path input to output.
- Stall and bubble are sampled on the same edge as data; the effect is visible after that edge.
- Reset deassertion is synchronised externally; the first edge with rst_n=1 performs normal priority evaluation.
- Reset mid-stall: the outputs return to reset values immediately; the held data is lost.

## Configuration
- PIPE_STAGE_REG_PERF_EN defined: stall_cnt, bubble_cnt and instr_cnt are implemented as described.
- PIPE_STAGE_REG_PERF_EN undefined: the counter ports remain, tied to 0; no counter flops are built; cnt_clr affects only ctl_err.

## Test plan
- Reset: hold rst_n=0 with inputs stat=3'b010, icode=4'h7 and clock running -> outputs stay stat=3'b001, icode=1, payload=0, valid=0, is_bubble=1; release -> next edge loads inputs.
- Normal load: in_icode=4'h3, ifun=0, payload=136'hABCD, valid=1 -> one edge later outputs match and is_bubble=0; instr_cnt=1.
- Stall: load icode=6, then assert stall for 3 edges while inputs change to icode=2 -> output stays icode=6; stall_cnt=3; the first edge after deassert shows icode=2.
- Bubble: registered icode=5 with payload nonzero, in_stat=3'b100, assert bubble for one edge -> icode=1, ifun=0, payload=0, stat=3'b001, valid=0, is_bubble=1; bubble_cnt=1.
- Conflict: stall=1 and bubble=1 for one edge -> bubble contents loaded and ctl_err=1, still 1 after 5 idle edges; cnt_clr for one edge -> ctl_err=0 and counters 0.
- Saturation (CNT_W=4, macro defined): 20 stall edges -> stall_cnt=4'hF; with the macro undefined -> all counters read 0 throughout.
